// File: rtl/io_bruecke.sv
// io_bruecke: bridge between the CPU data port, the data RAM and a small bank
// of memory-mapped I/O registers (output channels, synchronised input
// channels, sticky bus-error status) with a RAM timeout and a stretched CPU reset.
module io_bruecke #(
   parameter int KANAELE        = 4,
   parameter int BREITE         = 8,
   parameter int RAM_ADRESSBITS = 8,
   parameter int IO_BIT         = 31,
   parameter int TIMEOUT        = 15,
   parameter int RESET_ZYKLEN   = 10
) (
   input  logic                        Clock,
   input  logic                        Reset,
   output logic                        CPUReset,
   input  logic                        LeseDaten,
   input  logic                        SchreibeDaten,
   input  logic [31:0]                 DatenAdresse,
   input  logic [31:0]                 DatenRaus,
   output logic [31:0]                 DatenRein,
   output logic                        DatenGeladen,
   output logic                        DatenGespeichert,
   output logic                        RAMLesenAn,
   output logic                        RAMSchreibenAn,
   output logic [RAM_ADRESSBITS-1:0]   RAMAdresse,
   output logic [31:0]                 RAMDatenRein,
   input  logic [31:0]                 RAMDatenRaus,
   input  logic                        RAMDatenBereit,
   input  logic                        RAMDatenGeschrieben,
   output logic [KANAELE*BREITE-1:0]   Ausgaenge,
   input  logic [KANAELE*BREITE-1:0]   Eingaenge,
   output logic                        Busfehler
);

   localparam int RESET_BITS = $clog2(RESET_ZYKLEN + 1);
   localparam int TIMER_BITS = $clog2(TIMEOUT + 1);
   localparam int KANAL_BITS = KANAELE * BREITE;

   typedef enum logic [1:0] {
      BEREIT,
      IO,
      RAM_WARTEN,
      LOESEN
   } state_t;

   state_t                      state;
   state_t                      next_state;
   logic [RESET_BITS-1:0]       reset_count;
   logic [TIMER_BITS-1:0]       timer;
   logic [7:0]                  io_index;
   logic [RAM_ADRESSBITS-1:0]   ram_addr;
   logic [31:0]                 write_data;
   logic                        is_write;
   logic [KANAL_BITS-1:0]       sync_a;
   logic [KANAL_BITS-1:0]       sync_b;
   logic [BREITE-1:0]           out_regs [KANAELE];
   logic [31:0]                 io_value;
   logic                        accept;
   logic                        ram_response;
   logic                        ram_timeout;

   assign RAMAdresse   = ram_addr;
   assign RAMDatenRein = write_data;

   for (genvar g = 0; g < KANAELE; g++) begin : g_out
      assign Ausgaenge[g*BREITE +: BREITE] = out_regs[g];
   end

   // Hold the CPU in reset for a fixed number of edges after the system reset releases.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         CPUReset    <= 1'b1;
         reset_count <= '0;
      end else if (CPUReset) begin
         if (reset_count == RESET_BITS'(RESET_ZYKLEN - 1))
            CPUReset <= 1'b0;
         else
            reset_count <= reset_count + 1'b1;
      end
   end

   // Two-flop synchroniser for the asynchronous input channels.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= Eingaenge;
         sync_b <= sync_a;
      end
   end

   // FSM state register.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset)
         state <= BEREIT;
      else
         state <= next_state;
   end

   // Next-state decode: acceptance, RAM completion/timeout and release after the request drops.
   always_comb begin
      next_state   = state;
      accept       = 1'b0;
      ram_response = 1'b0;
      ram_timeout  = 1'b0;
      case (state)
         BEREIT: begin
            if (!CPUReset && (LeseDaten || SchreibeDaten)) begin
               accept     = 1'b1;
               next_state = DatenAdresse[IO_BIT] ? IO : RAM_WARTEN;
            end
         end
         IO: next_state = LOESEN;
         RAM_WARTEN: begin
            ram_response = is_write ? RAMDatenGeschrieben : RAMDatenBereit;
            if (ram_response)
               next_state = LOESEN;
            else if (timer == TIMER_BITS'(TIMEOUT - 1)) begin
               ram_timeout = 1'b1;
               next_state  = LOESEN;
            end
         end
         LOESEN: begin
            if (!LeseDaten && !SchreibeDaten)
               next_state = BEREIT;
         end
         default: next_state = BEREIT;
      endcase
   end

   // I/O read multiplexer; unmapped indices read as zero.
   always_comb begin
      io_value = '0;
      for (int i = 0; i < KANAELE; i++) begin
         if (io_index == 8'(i))
            io_value = 32'(out_regs[i]);
         if (io_index == 8'(KANAELE + i))
            io_value = 32'(sync_b[i*BREITE +: BREITE]);
      end
      if (io_index == 8'(2 * KANAELE))
         io_value = {31'b0, Busfehler};
   end

   // Request latching, I/O register access, RAM strobes, done pulses and the bus-error flag.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         io_index         <= '0;
         ram_addr         <= '0;
         write_data       <= '0;
         is_write         <= 1'b0;
         timer            <= '0;
         DatenRein        <= '0;
         DatenGeladen     <= 1'b0;
         DatenGespeichert <= 1'b0;
         RAMLesenAn       <= 1'b0;
         RAMSchreibenAn   <= 1'b0;
         Busfehler        <= 1'b0;
         for (int i = 0; i < KANAELE; i++)
            out_regs[i] <= '0;
      end else begin
         DatenGeladen     <= 1'b0;
         DatenGespeichert <= 1'b0;

         if (accept) begin
            io_index   <= DatenAdresse[7:0];
            ram_addr   <= DatenAdresse[RAM_ADRESSBITS-1:0];
            write_data <= DatenRaus;
            is_write   <= SchreibeDaten;
            timer      <= '0;
            if (!DatenAdresse[IO_BIT]) begin
               RAMLesenAn     <= !SchreibeDaten;
               RAMSchreibenAn <= SchreibeDaten;
            end
         end

         if (state == IO) begin
            if (is_write) begin
               for (int i = 0; i < KANAELE; i++) begin
                  if (io_index == 8'(i))
                     out_regs[i] <= write_data[BREITE-1:0];
               end
               if (io_index == 8'(2 * KANAELE) && write_data[0])
                  Busfehler <= 1'b0;
               DatenGespeichert <= 1'b1;
            end else begin
               DatenRein    <= io_value;
               DatenGeladen <= 1'b1;
            end
         end

         if (state == RAM_WARTEN) begin
            if (ram_response || ram_timeout) begin
               RAMLesenAn     <= 1'b0;
               RAMSchreibenAn <= 1'b0;
               if (is_write)
                  DatenGespeichert <= 1'b1;
               else begin
                  DatenGeladen <= 1'b1;
                  DatenRein    <= ram_response ? RAMDatenRaus : 32'hFFFF_FFFF;
               end
            end else begin
               timer <= timer + 1'b1;
            end
            if (ram_timeout)
               Busfehler <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_io_bruecke.sv
// tb_io_bruecke: directed tests for io_bruecke with hand-computed expectations
// (K=4, B=8, TIMEOUT=15, RESET_ZYKLEN=10).
module tb_io_bruecke;

   logic        clock = 1'b0;
   logic        resetN;
   logic        cpuReset;
   logic        leseDaten;
   logic        schreibeDaten;
   logic [31:0] datenAdresse;
   logic [31:0] datenRaus;
   logic [31:0] datenRein;
   logic        datenGeladen;
   logic        datenGespeichert;
   logic        ramLesenAn;
   logic        ramSchreibenAn;
   logic [7:0]  ramAdresse;
   logic [31:0] ramDatenRein;
   logic [31:0] ramDatenRaus;
   logic        ramDatenBereit;
   logic        ramDatenGeschrieben;
   logic [31:0] ausgaenge;
   logic [31:0] eingaenge;
   logic        busfehler;

   int          total = 0;
   int          bad = 0;

   logic [31:0] resData;
   logic [31:0] resAus;
   logic [31:0] resRamWdata;
   logic [7:0]  resRamAddr;
   logic        resLoaded;
   logic        resStored;
   logic        resStrobe;
   int          resCycles;
   int          resExtra;
   int          pulseCount;

   io_bruecke dut (
      .Clock               (clock),
      .Reset               (resetN),
      .CPUReset            (cpuReset),
      .LeseDaten           (leseDaten),
      .SchreibeDaten       (schreibeDaten),
      .DatenAdresse        (datenAdresse),
      .DatenRaus           (datenRaus),
      .DatenRein           (datenRein),
      .DatenGeladen        (datenGeladen),
      .DatenGespeichert    (datenGespeichert),
      .RAMLesenAn          (ramLesenAn),
      .RAMSchreibenAn      (ramSchreibenAn),
      .RAMAdresse          (ramAdresse),
      .RAMDatenRein        (ramDatenRein),
      .RAMDatenRaus        (ramDatenRaus),
      .RAMDatenBereit      (ramDatenBereit),
      .RAMDatenGeschrieben (ramDatenGeschrieben),
      .Ausgaenge           (ausgaenge),
      .Eingaenge           (eingaenge),
      .Busfehler           (busfehler)
   );

   // 100 MHz clock
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
      end
   endtask

   // One CPU access: drives the request at a falling edge, plays the RAM
   // (responding on the ramLat-th strobe cycle, 0 = never), records the done
   // cycle, holds the request three more cycles to catch a second access,
   // then releases it.
   task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] data, input int ramLat, input logic [31:0] ramData);
      int   strobeCycles;
      logic done;
      @(negedge clock);
      leseDaten     = rd;
      schreibeDaten = wr;
      datenAdresse  = addr;
      datenRaus     = data;
      resCycles     = 0;
      resExtra      = 0;
      resLoaded     = 1'b0;
      resStored     = 1'b0;
      resStrobe     = 1'b0;
      resRamAddr    = '0;
      resRamWdata   = '0;
      strobeCycles  = 0;
      done          = 1'b0;
      while (!done && resCycles < 40) begin
         @(negedge clock);
         resCycles++;
         ramDatenBereit      = 1'b0;
         ramDatenGeschrieben = 1'b0;
         if (datenGeladen || datenGespeichert) begin
            done      = 1'b1;
            resLoaded = datenGeladen;
            resStored = datenGespeichert;
            resData   = datenRein;
            resAus    = ausgaenge;
            resStrobe = ramLesenAn | ramSchreibenAn;
         end else if (ramLesenAn || ramSchreibenAn) begin
            strobeCycles++;
            if (strobeCycles == 1) begin
               resRamAddr  = ramAdresse;
               resRamWdata = ramDatenRein;
            end
            if (strobeCycles == ramLat) begin
               ramDatenBereit      = ramLesenAn;
               ramDatenGeschrieben = ramSchreibenAn;
               ramDatenRaus        = ramData;
            end
         end
      end
      if (!done)
         checkOutput("done_within_bound", 32'd0, 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         if (datenGeladen || datenGespeichert || ramLesenAn || ramSchreibenAn)
            resExtra++;
      end
      leseDaten     = 1'b0;
      schreibeDaten = 1'b0;
      @(negedge clock);
      if (datenGeladen || datenGespeichert)
         resExtra++;
   endtask

   initial begin
      resetN              = 1'b0;
      leseDaten           = 1'b0;
      schreibeDaten       = 1'b0;
      datenAdresse        = '0;
      datenRaus           = '0;
      ramDatenRaus        = '0;
      ramDatenBereit      = 1'b0;
      ramDatenGeschrieben = 1'b0;
      eingaenge           = '0;
      pulseCount          = 0;

      // reset values
      @(negedge clock);
      @(negedge clock);
      checkOutput("rst_cpureset", 32'(cpuReset), 32'd1);
      checkOutput("rst_ausgaenge", ausgaenge, 32'd0);
      checkOutput("rst_busfehler", 32'(busfehler), 32'd0);
      checkOutput("rst_geladen", 32'(datenGeladen), 32'd0);
      checkOutput("rst_strobes", 32'({ramLesenAn, ramSchreibenAn}), 32'd0);

      // reset stretch with a read request held during it
      resetN       = 1'b1;
      leseDaten    = 1'b1;
      datenAdresse = 32'h8000_0000;
      for (int i = 1; i <= 9; i++) begin
         @(negedge clock);
         checkOutput("stretch_cpureset_high", 32'(cpuReset), 32'd1);
         if (datenGeladen || datenGespeichert) pulseCount++;
      end
      @(negedge clock);
      checkOutput("stretch_cpureset_low", 32'(cpuReset), 32'd0);
      leseDaten = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         if (datenGeladen || datenGespeichert) pulseCount++;
      end
      checkOutput("stretch_no_response", 32'(pulseCount), 32'd0);

      // I/O write 0xA5 to channel 2
      applyStimulus(1'b0, 1'b1, 32'h8000_0002, 32'h0000_00A5, 0, 32'h0);
      checkOutput("iowr_stored", 32'(resStored), 32'd1);
      checkOutput("iowr_loaded", 32'(resLoaded), 32'd0);
      checkOutput("iowr_latency", 32'(resCycles), 32'd2);
      checkOutput("iowr_ausgaenge", resAus, 32'h00A5_0000);
      checkOutput("iowr_single", 32'(resExtra), 32'd0);

      // read channel 2 back
      applyStimulus(1'b1, 1'b0, 32'h8000_0002, 32'h0, 0, 32'h0);
      checkOutput("iord_loaded", 32'(resLoaded), 32'd1);
      checkOutput("iord_data", resData, 32'h0000_00A5);

      // write to an input register is ignored but completes
      applyStimulus(1'b0, 1'b1, 32'h8000_0004, 32'h0000_00FF, 0, 32'h0);
      checkOutput("inwr_stored", 32'(resStored), 32'd1);
      checkOutput("inwr_ausgaenge", ausgaenge, 32'h00A5_0000);

      // unmapped index 9 reads zero and completes
      applyStimulus(1'b1, 1'b0, 32'h8000_0009, 32'h0, 0, 32'h0);
      checkOutput("unmapped_loaded", 32'(resLoaded), 32'd1);
      checkOutput("unmapped_data", resData, 32'h0);

      // synchronised input channels 1 and 3
      eingaenge = 32'h8100_3C00;
      @(negedge clock);
      @(negedge clock);
      applyStimulus(1'b1, 1'b0, 32'h8000_0005, 32'h0, 0, 32'h0);
      checkOutput("in1_data", resData, 32'h0000_003C);
      applyStimulus(1'b1, 1'b0, 32'h8000_0007, 32'h0, 0, 32'h0);
      checkOutput("in3_data", resData, 32'h0000_0081);

      // RAM read, 3-cycle latency
      applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0, 3, 32'h1234_5678);
      checkOutput("ramrd_addr", 32'(resRamAddr), 32'h10);
      checkOutput("ramrd_loaded", 32'(resLoaded), 32'd1);
      checkOutput("ramrd_data", resData, 32'h1234_5678);
      checkOutput("ramrd_latency", 32'(resCycles), 32'd4);
      checkOutput("ramrd_strobe_low", 32'(resStrobe), 32'd0);
      checkOutput("ramrd_single", 32'(resExtra), 32'd0);

      // RAM write, 2-cycle latency
      applyStimulus(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 2, 32'h0);
      checkOutput("ramwr_addr", 32'(resRamAddr), 32'h20);
      checkOutput("ramwr_wdata", resRamWdata, 32'hCAFE_F00D);
      checkOutput("ramwr_stored", 32'(resStored), 32'd1);
      checkOutput("ramwr_latency", 32'(resCycles), 32'd3);

      // RAM read timeout
      applyStimulus(1'b1, 1'b0, 32'h0000_0030, 32'h0, 0, 32'h0);
      checkOutput("tord_latency", 32'(resCycles), 32'd16);
      checkOutput("tord_data", resData, 32'hFFFF_FFFF);
      checkOutput("tord_busfehler", 32'(busfehler), 32'd1);
      checkOutput("tord_single", 32'(resExtra), 32'd0);

      // status register read, then write-1-to-clear
      applyStimulus(1'b1, 1'b0, 32'h8000_0008, 32'h0, 0, 32'h0);
      checkOutput("status_read", resData, 32'h0000_0001);
      applyStimulus(1'b0, 1'b1, 32'h8000_0008, 32'h0000_0001, 0, 32'h0);
      checkOutput("status_w1c", 32'(busfehler), 32'd0);

      // both requests high: write wins, read data holds
      applyStimulus(1'b1, 1'b1, 32'h8000_0000, 32'h0000_005A, 0, 32'h0);
      checkOutput("both_stored", 32'(resStored), 32'd1);
      checkOutput("both_loaded", 32'(resLoaded), 32'd0);
      checkOutput("both_ausgaenge", resAus, 32'h00A5_005A);
      checkOutput("both_rein_hold", datenRein, 32'h0000_0001);

      // RAM write timeout sets the error flag again
      applyStimulus(1'b0, 1'b1, 32'h0000_0040, 32'h1111_2222, 0, 32'h0);
      checkOutput("towr_stored", 32'(resStored), 32'd1);
      checkOutput("towr_latency", 32'(resCycles), 32'd16);
      checkOutput("towr_busfehler", 32'(busfehler), 32'd1);
      checkOutput("towr_rein_hold", datenRein, 32'h0000_0001);

      // reset pulsed while waiting on RAM
      @(negedge clock);
      leseDaten    = 1'b1;
      datenAdresse = 32'h0000_0050;
      @(negedge clock);
      @(negedge clock);
      @(negedge clock);
      checkOutput("abort_strobe_before", 32'(ramLesenAn), 32'd1);
      resetN    = 1'b0;
      leseDaten = 1'b0;
      #1;
      checkOutput("abort_strobe_dropped", 32'(ramLesenAn), 32'd0);
      checkOutput("abort_busfehler", 32'(busfehler), 32'd0);
      checkOutput("abort_cpureset", 32'(cpuReset), 32'd1);
      @(negedge clock);
      resetN     = 1'b1;
      pulseCount = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clock);
         if (datenGeladen || datenGespeichert || ramLesenAn || ramSchreibenAn) pulseCount++;
      end
      checkOutput("abort_no_pulse", 32'(pulseCount), 32'd0);
      checkOutput("abort_cpureset_done", 32'(cpuReset), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/io_bruecke.md
# io_bruecke

Parametrised data-port bridge between the CPU data interface and the data RAM plus a bank of memory-mapped I/O registers. It replaces the fixed single-LED decode and the free-running reset counter with several registers:
- KANAELE output registers and KANAELE synchronised input registers.
- A status register with a sticky bus-error flag.
- A RAM response timeout.
- A stretched CPU reset.

It sits between the CPU data port and the data RAM instance in the top level.

## Interface
- KANAELE, 4: number of output and input channels (1..16)
- BREITE, 8: width of each channel register (1..32)
- RAM_ADRESSBITS, 8: RAM word-address width
- IO_BIT, 31: address bit selecting I/O (1) vs RAM (0)
- TIMEOUT, 15: max cycles waiting for RAM response (≥2)
- RESET_ZYKLEN, 10: CPUReset stretch length in cycles (≥1)

Ports:
- Clock  in  1  system clock, all logic on rising edge
- Reset  in  1  asynchronous, active-low reset
- CPUReset  out  1  active-high CPU reset, stretched
- LeseDaten  in  1  CPU read request (level, held until completion)
- SchreibeDaten  in  1  CPU write request (level, held until completion)
- DatenAdresse  in  32  CPU word address
- DatenRaus  in  32  CPU write data
- DatenRein  out  32  read data to CPU
- DatenGeladen  out  1  read complete, one-cycle pulse
- DatenGespeichert  out  1  write complete, one-cycle pulse
- RAMLesenAn / RAMSchreibenAn  out  1  RAM strobes
- RAMAdresse  out  RAM_ADRESSBITS  RAM word address
- RAMDatenRein  out  32  RAM write data
- RAMDatenRaus  in  32  RAM read data
- RAMDatenBereit / RAMDatenGeschrieben  in  1  RAM completion
- Ausgaenge  out  KANAELE*BREITE  output registers, channel i at [i*BREITE +: BREITE]
- Eingaenge  in  KANAELE*BREITE  asynchronous inputs
- Busfehler  out  1  sticky timeout flag

## Operation

**Reset.** While Reset=0, every register clears:
- All outputs are 0, except CPUReset=1.
- FSM is in BEREIT.
- Synchronisers are cleared.

**CPUReset stretch.** After Reset rises, CPUReset stays 1 for exactly RESET_ZYKLEN rising edges, then drops to 0. Requests are ignored while CPUReset=1.

**Request acceptance.** A request is accepted in BEREIT. Address, data and type are latched. If SchreibeDaten=1 and LeseDaten=1 together, the access is a write.

**I/O map.** An access is I/O when DatenAdresse[IO_BIT]=1. The index is DatenAdresse[7:0]:
- 0..K-1: output register, read/write. Reads return the value zero-extended.
- K..2K-1: input register, read-only. Returns the 2-flop-synchronised Eingaenge value. Writes are ignored.
- 2K: status register. bit0=Busfehler. Writing 1 to bit0 clears it (write-1-to-clear).
- Any other index: reads return 0, writes are ignored. The access still completes.

**RAM accesses.** The latched request drives RAMAdresse=DatenAdresse[RAM_ADRESSBITS-1:0] and RAMDatenRein=DatenRaus. The matching strobe is held until the RAM responds or the timeout expires.

**FSM states.**
- BEREIT: on an accepted request, go to IO or RAM_WARTEN.
- IO: perform the access and go to LOESEN with the done pulse.
- RAM_WARTEN: on response, capture RAMDatenRaus into DatenRein, drop the strobe, pulse done, go to LOESEN. After TIMEOUT cycles with no response, drop the strobe, set Busfehler=1, return DatenRein=32'hFFFF_FFFF (read) or discard (write), pulse done, go to LOESEN.
- LOESEN: go to BEREIT once LeseDaten=0 and SchreibeDaten=0 are sampled. This prevents one held request from being processed twice.

**Other rules.**
- Busfehler set and clear on the same edge: set wins.
- DatenRein holds its last value until the next read completes.

## Timing
- Request sampled at edge E0 → state change and RAM strobe asserted after E0.
- I/O access: done pulse high E1..E2. Output register updated at E1. Latency is 1 cycle after acceptance.
- RAM access: done pulse is high in the cycle after the edge that samples the RAM response. The strobe is low in that same cycle.
- Timeout: done pulse in the cycle after edge E0+TIMEOUT.
- Done pulses last exactly 1 cycle. DatenRein is valid whenever DatenGeladen=1.
- Minimum spacing between two accesses: 3 cycles (accept, done, LOESEN release).
- Reset asserted mid-transaction: immediate abort. Strobes and done pulses go low, no pulse is emitted after release, Busfehler is cleared.

## Test plan
- Reset released, RESET_ZYKLEN=10 → CPUReset=1 for exactly 10 edges; Ausgaenge=0, Busfehler=0; a request during the stretch gets no response.
- I/O write 0x000000A5 to 0x80000002 (K=4, B=8) → Ausgaenge[23:16]=8'hA5 one cycle after acceptance, DatenGespeichert high 1 cycle; read back → DatenRein=0x000000A5.
- Eingaenge channel 1 = 8'h3C, read 0x80000005 → DatenRein=0x0000003C, valid ≥2 cycles after the input changes.
- RAM model with 3-cycle read latency returning 0x12345678 at address 0x10 → RAMAdresse=0x10, DatenGeladen pulses once with 0x12345678, no second access while the request is still held.
- RAM never responds → DatenGeladen after 15 cycles with 0xFFFFFFFF, Busfehler=1; write 1 to 0x80000008 → Busfehler=0.
- LeseDaten and SchreibeDaten both high to 0x80000000 → write performed, only DatenGespeichert pulses; Reset pulsed during RAM_WARTEN → strobes drop immediately, no done pulse after release.
